// File: rtl/router_input_port.sv
// router_input_port: per-source ingress stage of the 16x16 router.
// Deserialises the LSB-first destination address, requests the arbiter, buffers
// payload bits as {last, data} FIFO entries and replays them serially once granted.
// Optional feature: define ROUTER_TIMEOUT_EN to abandon a packet whose grant does
// not arrive within TIMEOUT cycles (adds the timeout_o port and a DISCARD state).

module router_input_port #(
    parameter int ADDR_W  = 4,
    parameter int DEPTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_n,
    input  logic              valid_n,
    input  logic              din,
    output logic              busy_n,
    output logic              req,
    output logic [ADDR_W-1:0] dest,
    input  logic              gnt,
    output logic              frameo_n,
    output logic              valido_n,
    output logic              dout,
    output logic              ovf
`ifdef ROUTER_TIMEOUT_EN
    ,
    output logic              timeout_o
`endif
);

    localparam int CNT_W  = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [PTR_W-1:0]  PTR_MAX   = PTR_W'(DEPTH - 1);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(DEPTH);

    generate
        if (ADDR_W < 2 || DEPTH < 2 || TIMEOUT < 1) begin : g_bad_param
            $error("router_input_port: ADDR_W and DEPTH must be >= 2, TIMEOUT >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_REQ     = 3'd2,
        S_SEND    = 3'd3
`ifdef ROUTER_TIMEOUT_EN
        ,
        S_DISCARD = 3'd4
`endif
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;

    logic [1:0]        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, tail_ptr;
    logic [FILL_W-1:0] fill;
    logic [1:0]        head;
    logic              push, pop, full, push_ok, drop, timed_out;

    // A push while full is only dropped when no pop frees a slot in the same cycle.
    assign push     = (state == S_REQ || state == S_SEND) && !valid_n;
    assign pop      = (state == S_SEND) && (fill != '0);
    assign full     = (fill == FILL_MAX);
    assign push_ok  = push && (!full || pop);
    assign drop     = push && full && !pop;
    assign head     = mem[rd_ptr];
    assign tail_ptr = (wr_ptr == '0) ? PTR_MAX : wr_ptr - 1'b1;

    assign busy_n = (state == S_IDLE);
    assign req    = (state == S_REQ) || (state == S_SEND);

`ifdef ROUTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0] tcnt;
    logic            got_last;

    assign timed_out = (state == S_REQ) && !gnt && (tcnt == TO_LAST);

    // Grant-wait counter, pulse on DISCARD entry, and memory of an already-seen last bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt      <= '0;
            got_last  <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= timed_out;
            tcnt      <= (state == S_REQ && !gnt) ? tcnt + 1'b1 : '0;
            if (state == S_IDLE)
                got_last <= 1'b0;
            else if (push && frame_n)
                got_last <= 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!frame_n) state_nxt = S_ADDR;
            S_ADDR: begin
                if (frame_n)
                    state_nxt = S_IDLE;
                else if (cnt == ADDR_LAST)
                    state_nxt = S_REQ;
            end
            S_REQ: begin
                if (gnt)
                    state_nxt = S_SEND;
`ifdef ROUTER_TIMEOUT_EN
                else if (timed_out)
                    state_nxt = S_DISCARD;
`endif
            end
            S_SEND:  if (pop && head[1]) state_nxt = S_IDLE;
`ifdef ROUTER_TIMEOUT_EN
            S_DISCARD: if (got_last || (frame_n && !valid_n)) state_nxt = S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and serial address capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            dest  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && !frame_n) begin
                dest[0] <= din;
                cnt     <= CNT_W'(1);
            end else if (state == S_ADDR && !frame_n) begin
                dest[cnt] <= din;
                cnt       <= cnt + 1'b1;
            end
        end
    end

    // FIFO pointers and fill level; the overflow flag is sticky until reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            ovf    <= 1'b0;
        end else begin
            if (drop)
                ovf <= 1'b1;
            if (timed_out) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                fill   <= '0;
            end else begin
                if (push_ok)
                    wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
                if (push_ok && !pop)
                    fill <= fill + 1'b1;
                else if (!push_ok && pop)
                    fill <= fill - 1'b1;
            end
        end
    end

    // FIFO storage; a dropped last bit still terminates the frame via the tail entry
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= {frame_n, din};
        else if (drop && frame_n)
            mem[tail_ptr][1] <= 1'b1;
    end

    // Registered serial replay; an empty FIFO mid-packet shows a bubble
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frameo_n <= 1'b1;
            valido_n <= 1'b1;
            dout     <= 1'b0;
        end else if (state == S_SEND) begin
            if (pop) begin
                frameo_n <= head[1];
                valido_n <= 1'b0;
                dout     <= head[0];
            end else begin
                frameo_n <= 1'b0;
                valido_n <= 1'b1;
            end
        end else begin
            frameo_n <= 1'b1;
            valido_n <= 1'b1;
        end
    end

endmodule

// File: tb/tb_router_input_port.sv
// tb_router_input_port: randomized and directed packets against a queue-based
// reference model of the ingress port, checked every cycle, plus literal checks.
`timescale 1ns/1ps

module tb_router_input_port;

    localparam int ADDR_W  = 4;
    localparam int DEPTH   = 32;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0, reset_n = 1'b0;
    logic frame_n = 1'b1, valid_n = 1'b1, din = 1'b0, gnt = 1'b0;
    logic busy_n, req, frameo_n, valido_n, dout, ovf;
    logic [ADDR_W-1:0] dest;
`ifdef ROUTER_TIMEOUT_EN
    logic timeout_o;
`endif

    router_input_port #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .frame_n(frame_n), .valid_n(valid_n), .din(din),
        .busy_n(busy_n), .req(req), .dest(dest), .gnt(gnt),
        .frameo_n(frameo_n), .valido_n(valido_n), .dout(dout), .ovf(ovf)
`ifdef ROUTER_TIMEOUT_EN
        , .timeout_o(timeout_o)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    // Reference model: packet phase, payload queue, expected registered outputs
    localparam int P_IDLE = 0, P_ADDR = 1, P_WAIT = 2, P_SEND = 3, P_DISC = 4;
    int               m_phase, m_abits, m_wcnt;
    logic [ADDR_W-1:0] m_dest;
    logic [1:0]       m_q[$];
    logic             m_fo, m_vo, m_dout, m_ovf, m_to, m_gotlast;

    // Observation for the directed literal checks
    logic             cap_bits[$];
    logic             cap_last[$];
    int               bubbles, req_seen, to_seen, gnt_wait;
    logic [ADDR_W-1:0] last_req_dest;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_abits = 0; m_wcnt = 0; m_dest = '0;
        m_q.delete();
        m_fo = 1'b1; m_vo = 1'b1; m_dout = 1'b0; m_ovf = 1'b0; m_to = 1'b0; m_gotlast = 1'b0;
    endtask

    // One clock edge of the specified behaviour, given the inputs seen at that edge
    task automatic model_step(input logic f, input logic v, input logic d, input logic g);
        logic [1:0] e;
        logic       popped_last;
        int         ph;
        ph = m_phase;
        popped_last = 1'b0;
        m_to = 1'b0;
        if (ph == P_SEND) begin
            if (m_q.size() > 0) begin
                e = m_q.pop_front();
                m_fo = e[1]; m_vo = 1'b0; m_dout = e[0]; popped_last = e[1];
            end else begin
                m_fo = 1'b0; m_vo = 1'b1;
            end
        end else begin
            m_fo = 1'b1; m_vo = 1'b1;
        end
        if ((ph == P_WAIT || ph == P_SEND) && !v) begin
            if (f) m_gotlast = 1'b1;
            if (m_q.size() < DEPTH) m_q.push_back({f, d});
            else begin
                m_ovf = 1'b1;
                if (f) begin
                    e = m_q.pop_back();
                    e[1] = 1'b1;
                    m_q.push_back(e);
                end
            end
        end
        case (ph)
            P_IDLE: if (!f) begin
                m_dest[0] = d; m_abits = 1; m_phase = P_ADDR; m_gotlast = 1'b0;
            end
            P_ADDR: begin
                if (f) m_phase = P_IDLE;
                else begin
                    m_dest[m_abits] = d;
                    m_abits++;
                    if (m_abits == ADDR_W) begin m_phase = P_WAIT; m_wcnt = 0; end
                end
            end
            P_WAIT: begin
                if (g) m_phase = P_SEND;
`ifdef ROUTER_TIMEOUT_EN
                else begin
                    m_wcnt++;
                    if (m_wcnt == TIMEOUT) begin m_q.delete(); m_phase = P_DISC; m_to = 1'b1; end
                end
`endif
            end
            P_SEND: if (popped_last) m_phase = P_IDLE;
            P_DISC: if (m_gotlast || (f && !v)) m_phase = P_IDLE;
            default: m_phase = P_IDLE;
        endcase
    endtask

    // Advance one cycle, step the model, compare every output just after the edge
    task automatic tick();
        @(posedge clk);
        model_step(frame_n, valid_n, din, gnt);
        #1;
        check("busy_n", busy_n, m_phase == P_IDLE);
        check("req", req, m_phase == P_WAIT || m_phase == P_SEND);
        check("dest", dest, m_dest);
        check("frameo_n", frameo_n, m_fo);
        check("valido_n", valido_n, m_vo);
        check("dout", dout, m_dout);
        check("ovf", ovf, m_ovf);
`ifdef ROUTER_TIMEOUT_EN
        check("timeout_o", timeout_o, m_to);
        if (timeout_o) to_seen++;
`endif
        if (valido_n == 1'b0) begin
            cap_bits.push_back(dout);
            cap_last.push_back(frameo_n);
        end else if (frameo_n == 1'b0) bubbles++;
        if (req) begin req_seen++; last_req_dest = dest; end
    endtask

    task automatic cyc(input logic f, input logic v, input logic d);
        frame_n = f; valid_n = v; din = d;
        gnt = (gnt_wait == 0);
        if (gnt_wait > 0) gnt_wait--;
        tick();
    endtask

    task automatic clear_cap();
        cap_bits.delete(); cap_last.delete();
        bubbles = 0; req_seen = 0; to_seen = 0;
    endtask

    // gap < 0 picks 0..2 idle-valid cycles before each payload bit after the first
    task automatic send_pkt(input logic [ADDR_W-1:0] a, input int n, input logic [127:0] pl,
                            input int gap);
        int k, g;
        for (int i = 0; i < ADDR_W; i++) cyc(1'b0, 1'($urandom), a[i]);
        for (int i = 0; i < n; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            if (i > 0) repeat (g) cyc(1'b0, 1'b1, 1'($urandom));
            cyc(1'(i == n - 1), 1'b0, pl[i]);
        end
        k = 0;
        while (m_phase != P_IDLE && k < 400) begin cyc(1'b1, 1'b1, 1'b0); k++; end
        check("drain_bound", k < 400, 1);
        repeat (2) cyc(1'b1, 1'b1, 1'b0);
    endtask

    function automatic logic [127:0] cap_value();
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < cap_bits.size(); i++) r[i] = cap_bits[i];
        return r;
    endfunction

    function automatic int cap_frame_hi();
        int c;
        c = 0;
        for (int i = 0; i < cap_last.size(); i++) if (cap_last[i]) c++;
        return c;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] pl;
        logic [ADDR_W-1:0] a;
        int n;
        model_reset();
        gnt_wait = 0;
        last_req_dest = '0;
        clear_cap();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy_n", busy_n, 1); check("rst_req", req, 0); check("rst_dest", dest, 0);
        check("rst_frameo_n", frameo_n, 1); check("rst_valido_n", valido_n, 1);
        check("rst_dout", dout, 0); check("rst_ovf", ovf, 0);
        @(negedge clk) reset_n = 1'b1;

        // Single packet, dest 4'b1010, payload A5, grant tied high
        clear_cap(); gnt_wait = 0;
        send_pkt(4'b1010, 8, 128'hA5, 0);
        check("t1_dest", last_req_dest, 4'd10);
        check("t1_nbits", cap_bits.size(), 8);
        check("t1_data", cap_value(), 128'hA5);
        check("t1_frame_hi", cap_frame_hi(), 1);
        check("t1_last_flag", cap_last[7], 1);
        check("t1_busy_after", busy_n, 1);

        // Grant withheld for 20 REQ cycles across a 12-bit payload
        clear_cap(); gnt_wait = 24; pl = 128'($urandom);
        send_pkt(4'h3, 12, pl, 0);
        check("t2_nbits", cap_bits.size(), 12);
        check("t2_data", cap_value(), pl & 128'hFFF);
        check("t2_bubbles", bubbles, 0);

        // Bit, gap, gap, bit with early grant
        clear_cap(); gnt_wait = 0;
        send_pkt(4'h5, 2, 128'h1, 2);
        check("t3_nbits", cap_bits.size(), 2);
        check("t3_data", cap_value(), 128'h1);
        check("t3_bubbles", bubbles, 2);

        // 40-bit payload into 32 entries with grant withheld
        clear_cap(); gnt_wait = 60; pl = {$urandom, $urandom, $urandom, $urandom};
        send_pkt(4'hC, 40, pl, 0);
        check("t4_ovf", ovf, 1);
        check("t4_nbits", cap_bits.size(), 32);
        check("t4_data", cap_value(), pl & {96'h0, 32'hFFFF_FFFF});
        check("t4_frame_hi", cap_frame_hi(), 1);
        check("t4_last_flag", cap_last[31], 1);

        // Abort after two address bits, then a normal packet
        clear_cap(); gnt_wait = 0;
        cyc(1'b0, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b0); cyc(1'b1, 1'b1, 1'b0);
        repeat (3) cyc(1'b1, 1'b1, 1'b0);
        check("t5_req_never", req_seen, 0);
        check("t5_idle", busy_n, 1);
        gnt_wait = 3;
        send_pkt(4'h6, 5, 128'h16, -1);
        check("t5_dest", last_req_dest, 4'h6);
        check("t5_data", cap_value(), 128'h16);

        // Reset asserted mid-SEND takes effect without a clock edge
        gnt_wait = 0;
        for (int i = 0; i < ADDR_W; i++) cyc(1'b0, 1'b1, 1'(i & 1));
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'($urandom));
        check("t6_pre_valid", valido_n, 0);
        check("t6_pre_ovf", ovf, 1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_busy_n", busy_n, 1); check("t6_req", req, 0); check("t6_dest", dest, 0);
        check("t6_frameo_n", frameo_n, 1); check("t6_valido_n", valido_n, 1);
        check("t6_dout", dout, 0); check("t6_ovf", ovf, 0);
        model_reset();
        frame_n = 1'b1; valid_n = 1'b1; din = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        // Randomized packets
        for (int p = 0; p < 30; p++) begin
            a = ADDR_W'($urandom);
            n = int'($urandom_range(1, 40));
            pl = {$urandom, $urandom, $urandom, $urandom};
            gnt_wait = int'($urandom_range(0, 50));
            clear_cap();
            send_pkt(a, n, pl, -1);
            check("rand_dest", last_req_dest, a);
        end

`ifdef ROUTER_TIMEOUT_EN
        // Grant never arrives: timeout, discard, back to idle
        clear_cap(); gnt_wait = 300;
        send_pkt(4'h9, 100, {$urandom, $urandom, $urandom, $urandom}, 0);
        check("to_pulse", to_seen, 1);
        check("to_no_output", cap_bits.size(), 0);
        check("to_req_low", req, 0);
        gnt_wait = 0;
        send_pkt(4'h2, 3, 128'h5, 0);
        check("to_next_data", cap_value(), 128'h5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
